lcd_hd44780_responder: RTL

LCD_HD44780_RESPONDER -- requirements
Module: lcd_hd44780_responder

---
 rtl/lcd_hd44780_responder.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_hd44780_responder.sv
// HD44780 character-LCD bus responder: decodes controller writes into a
// 2-line DDRAM model, an address counter and display-control flags, and
// emulates the busy timing of the real part.
// Optional feature: define LCD_RSP_READ_EN to answer bus reads (status/data).
module lcd_hd44780_responder #(
  parameter int unsigned CMD_BUSY_CYC   = 2000,
  parameter int unsigned CLEAR_BUSY_CYC = 82000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned CntW = $clog2(CLEAR_BUSY_CYC + 1);

  typedef enum logic [1:0] {StIdle, StExec, StClearSweep, StBusyWait} state_e;

  // Next address in the two valid windows 0x00-0x27 / 0x40-0x67.
  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic inc);
    if (inc) begin
      if (a == 7'h27)      ac_step = 7'h40;
      else if (a == 7'h67) ac_step = 7'h00;
      else                 ac_step = a + 7'd1;
    end else begin
      if (a == 7'h00)      ac_step = 7'h67;
      else if (a == 7'h40) ac_step = 7'h27;
      else                 ac_step = a - 7'd1;
    end
  endfunction

  function automatic logic addr_valid(input logic [6:0] a);
    addr_valid = (a[5:0] <= 6'h27);
  endfunction

  // Out-of-window set-DDRAM addresses snap to the start of the next line.
  function automatic logic [6:0] ddram_map(input logic [6:0] a);
    if (a >= 7'h28 && a <= 7'h3f)      ddram_map = 7'h40;
    else if (a >= 7'h68)               ddram_map = 7'h00;
    else                               ddram_map = a;
  endfunction

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]     sweep_q, sweep_d;
  logic [6:0]     ac_q, ac_d;
  logic           id_q, id_d;
  logic           ddram_sel_q, ddram_sel_d;
  logic           disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d;
  logic           overrun_q, overrun_d;
  logic           cmd_rs_q, cmd_rs_d;
  logic [7:0]     cmd_data_q, cmd_data_d;
  logic           en_s1_q, en_s2_q, en_s3_q;
  logic           en_fall, wr_xfer;
  logic           mem_we;
  logic [6:0]     mem_waddr;
  logic [7:0]     mem_wdata;
  logic [7:0]     mem_q [128];
  logic [7:0]     rd_data_q;

  assign en_fall = en_s3_q & ~en_s2_q;
  assign wr_xfer = en_fall & ~lcd_rw;

  // Enable synchroniser plus edge-detect flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      en_s3_q <= 1'b0;
    end else begin
      en_s1_q <= lcd_en;
      en_s2_q <= en_s1_q;
      en_s3_q <= en_s2_q;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sweep_q     <= '0;
      ac_q        <= '0;
      id_q        <= 1'b1;
      ddram_sel_q <= 1'b1;
      disp_q      <= 1'b0;
      cursor_q    <= 1'b0;
      blink_q     <= 1'b0;
      overrun_q   <= 1'b0;
      cmd_rs_q    <= 1'b0;
      cmd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sweep_q     <= sweep_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      ddram_sel_q <= ddram_sel_d;
      disp_q      <= disp_d;
      cursor_q    <= cursor_d;
      blink_q     <= blink_d;
      overrun_q   <= overrun_d;
      cmd_rs_q    <= cmd_rs_d;
      cmd_data_q  <= cmd_data_d;
    end
  end

  // Transfer decode, clear sweep and busy timing.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sweep_d     = sweep_q;
    ac_d        = ac_q;
    id_d        = id_q;
    ddram_sel_d = ddram_sel_q;
    disp_d      = disp_q;
    cursor_d    = cursor_q;
    blink_d     = blink_q;
    cmd_rs_d    = cmd_rs_q;
    cmd_data_d  = cmd_data_q;
    overrun_d   = wr_xfer && (state_q != StIdle);
    mem_we      = 1'b0;
    mem_waddr   = ac_q;
    mem_wdata   = cmd_data_q;

`ifdef LCD_RSP_READ_EN
    // Data reads step AC on their falling edge, even while busy.
    if (en_fall && lcd_rw && lcd_rs && state_q != StExec) ac_d = ac_step(ac_q, id_q);
`endif

    case (state_q)
      StIdle: begin
        if (wr_xfer) begin
          cmd_rs_d   = lcd_rs;
          cmd_data_d = lcd_data_in;
          state_d    = StExec;
        end
      end
      StExec: begin
        state_d = StBusyWait;
        cnt_d   = CntW'(CMD_BUSY_CYC - 2);
        if (cmd_rs_q) begin
          // CGRAM data is discarded; only DDRAM writes land.
          if (ddram_sel_q) begin
            mem_we = 1'b1;
            ac_d   = ac_step(ac_q, id_q);
          end
        end else if (cmd_data_q[7]) begin
          ddram_sel_d = 1'b1;
          ac_d        = ddram_map(cmd_data_q[6:0]);
        end else if (cmd_data_q[6]) begin
          ddram_sel_d = 1'b0;
        end else if (cmd_data_q[5]) begin
          // Function set: no modelled state.
        end else if (cmd_data_q[4]) begin
          if (!cmd_data_q[3]) ac_d = ac_step(ac_q, cmd_data_q[2]);
        end else if (cmd_data_q[3]) begin
          disp_d   = cmd_data_q[2];
          cursor_d = cmd_data_q[1];
          blink_d  = cmd_data_q[0];
        end else if (cmd_data_q[2]) begin
          id_d = cmd_data_q[1];
        end else if (cmd_data_q[1]) begin
          ac_d  = '0;
          cnt_d = CntW'(CLEAR_BUSY_CYC - 2);
        end else if (cmd_data_q[0]) begin
          state_d = StClearSweep;
          sweep_d = '0;
          cnt_d   = CntW'(CLEAR_BUSY_CYC - 2);
        end
      end
      StClearSweep: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = 8'h20;
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        if (sweep_q == 7'h67) begin
          ac_d        = '0;
          id_d        = 1'b1;
          ddram_sel_d = 1'b1;
          state_d     = StBusyWait;
        end else begin
          sweep_d = ac_step(sweep_q, 1'b1);
        end
      end
      StBusyWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // DDRAM array and scan port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    rd_data_q <= addr_valid(rd_addr) ? mem_q[rd_addr] : 8'h20;
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = ac_q;
  assign disp_on     = disp_q;
  assign cursor_on   = cursor_q;
  assign blink_on    = blink_q;
  assign busy        = (state_q != StIdle);
  assign overrun     = overrun_q;

`ifdef LCD_RSP_READ_EN
  // Bus read drive while the synchronised strobe is high.
  always_comb begin
    lcd_data_oe  = en_s2_q & lcd_rw;
    lcd_data_out = 8'h00;
    if (lcd_data_oe) lcd_data_out = lcd_rs ? mem_q[ac_q] : {busy, ac_q};
  end
`else
  assign lcd_data_oe  = 1'b0;
  assign lcd_data_out = 8'h00;
`endif

endmodule
